// File: rtl/v_line_cfg_ctrl_if.sv
// Wishbone slave bus bundle for the vertical-line configuration controller.
interface v_line_cfg_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/v_line_cfg_ctrl.sv
// Owns the v_line mux configuration bus; every change is sequenced as
// outputs off -> guard -> switch -> guard -> outputs on.
module v_line_cfg_ctrl #(
    parameter logic [31:0]        BASE_ADDR   = 32'h3000_0000,
    parameter logic [31:0]        ADDR_MASK   = 32'hFFFF_FFF0,
    parameter int unsigned        NUM_CFG     = 4,
    parameter logic [3:0]         RESET_CFG   = 4'd0,
    parameter int unsigned        GUARD_W     = 8,
    parameter logic [GUARD_W-1:0] GUARD_RESET = GUARD_W'(4)
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    v_line_cfg_ctrl_if.slave        wb,
    output logic [3:0]              configuration,
    output logic                    oe_enable,
    output logic                    busy,
    output logic                    cfg_done
);

    typedef enum logic [1:0] {StIdle, StDrain, StSwitch, StSettle} state_e;

    state_e             state_q, state_d;
    logic [GUARD_W-1:0] cnt_q, cnt_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic [3:0]         req_q, req_d;
    logic [3:0]         target_q, target_d;
    logic [3:0]         cfg_q, cfg_d;
    logic               pending_q, pending_d;
    logic               err_q, err_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic               done_q, done_d;

    logic        hit, access, wr, req_valid;
    logic [1:0]  off;
    logic [31:0] rdata;

    assign hit       = (wb.wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    assign access    = wb.wbs_stb_i & wb.wbs_cyc_i & hit & ~ack_q;
    assign wr        = access & wb.wbs_we_i;
    assign off       = wb.wbs_adr_i[3:2];
    assign req_valid = 32'(wb.wbs_dat_i[3:0]) < NUM_CFG;

    assign configuration = cfg_q;
    assign oe_enable     = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign cfg_done      = done_q;
    assign wb.wbs_ack_o  = ack_q;
    assign wb.wbs_dat_o  = dat_q;

    always_comb begin
        unique case (off)
            2'd0:    rdata = {28'd0, req_q};
            2'd1:    rdata = 32'(guard_q);
            2'd2:    rdata = {24'd0, cfg_q, 1'b0, err_q, pending_q, busy};
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        cfg_d     = cfg_q;
        done_d    = 1'b0;
        req_d     = req_q;
        pending_d = pending_q;
        err_d     = err_q;
        guard_d   = guard_q;
        ack_d     = access;
        dat_d     = access ? rdata : 32'd0;

        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    // Latch the target so later writes only queue the next sequence.
                    state_d   = StDrain;
                    cnt_d     = guard_q;
                    target_d  = req_q;
                    pending_d = 1'b0;
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StSwitch;
                    cfg_d   = target_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSwitch: begin
                state_d = StSettle;
                cnt_d   = guard_q;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Bus writes follow the FSM so a write on a launch edge re-arms pending.
        if (wr) begin
            unique case (off)
                2'd0: begin
                    if (wb.wbs_sel_i[0]) begin
                        if (!req_valid) begin
                            err_d = 1'b1;
                        end else if (!(state_q == StIdle && wb.wbs_dat_i[3:0] == cfg_q)) begin
                            req_d     = wb.wbs_dat_i[3:0];
                            pending_d = 1'b1;
                        end
                    end
                end
                2'd1: begin
                    for (int i = 0; i < int'(GUARD_W); i++) begin
                        if (wb.wbs_sel_i[i/8]) guard_d[i] = wb.wbs_dat_i[i];
                    end
                end
                2'd2: begin
                    if (wb.wbs_sel_i[0] && wb.wbs_dat_i[2]) err_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q   <= StSettle;
            cnt_q     <= GUARD_RESET;
            guard_q   <= GUARD_RESET;
            req_q     <= RESET_CFG;
            target_q  <= RESET_CFG;
            cfg_q     <= RESET_CFG;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            guard_q   <= guard_d;
            req_q     <= req_d;
            target_q  <= target_d;
            cfg_q     <= cfg_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_v_line_cfg_ctrl.sv
// Directed bench for v_line_cfg_ctrl: register access, sequencing timing, errors, reset.
module tb_v_line_cfg_ctrl;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CFG  = BASE + 32'h0;
    localparam logic [31:0] A_GRD  = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] configuration;
    logic       oe_enable, busy, cfg_done;

    int tests = 0;
    int fails = 0;

    // Observed waveform statistics, sampled on the falling edge.
    int         low_run = 0, high_run = 0, last_low = 0, last_high = 0;
    int         done_cnt = 0, cfg_chg_at = -1;
    logic [3:0] prev_cfg = 4'd0;

    v_line_cfg_ctrl_if wb ();

    v_line_cfg_ctrl dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst_n),
        .wb            (wb),
        .configuration (configuration),
        .oe_enable     (oe_enable),
        .busy          (busy),
        .cfg_done      (cfg_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_n) begin
            low_run  = 0;
            high_run = 0;
            prev_cfg = configuration;
        end else begin
            if (cfg_done) done_cnt++;
            if (!oe_enable) begin
                if (high_run > 0) last_high = high_run;
                high_run = 0;
                low_run++;
                if (configuration != prev_cfg) cfg_chg_at = low_run - 1;
            end else begin
                if (low_run > 0) last_low = low_run;
                low_run = 0;
                high_run++;
            end
            prev_cfg = configuration;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        check("wr_ack", 32'(wb.wbs_ack_o), 32'd1);
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        @(posedge clk); #1;
        check("wr_ack_drop", 32'(wb.wbs_ack_o), 32'd0);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        wb.wbs_adr_i = adr;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        check("rd_ack", 32'(wb.wbs_ack_o), 32'd1);
        dat = wb.wbs_dat_o;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (done_cnt < target && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 32'(done_cnt >= target), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        int          base;
        int          k;
        int          acks;

        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_dat_i = 32'd0;
        wb.wbs_adr_i = 32'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg", 32'(configuration), 32'd0);
        check("rst_oe", 32'(oe_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
        check("rst_dat", wb.wbs_dat_o, 32'd0);

        // Reset release: 5 low cycles then cfg_done
        rst_n = 1'b1;
        base  = done_cnt;
        wait_done(base + 1, "rel_done");
        check("rel_low", 32'(last_low), 32'd5);
        check("rel_oe", 32'(oe_enable), 32'd1);
        check("rel_cfg", 32'(configuration), 32'd0);
        wb_read(A_STAT, rd);
        check("rel_status", rd, 32'h00);

        // Change to 2 with guard 4
        base = done_cnt;
        wb_write(A_CFG, 32'd2, 4'hF);
        check("seq2_busy", 32'(busy), 32'd1);
        wait_done(base + 1, "seq2_done");
        repeat (3) @(posedge clk);
        #1;
        check("seq2_low", 32'(last_low), 32'd11);
        check("seq2_sw_at", 32'(cfg_chg_at), 32'd5);
        check("seq2_ndone", 32'(done_cnt - base), 32'd1);
        check("seq2_cfg", 32'(configuration), 32'd2);
        wb_read(A_STAT, rd);
        check("seq2_status", rd, 32'h20);
        wb_read(A_CFG, rd);
        check("seq2_req", rd, 32'd2);

        // Illegal request sets sticky err only
        wb_write(A_CFG, 32'd5, 4'hF);
        check("err_cfg", 32'(configuration), 32'd2);
        check("err_oe", 32'(oe_enable), 32'd1);
        wb_read(A_STAT, rd);
        check("err_status", rd, 32'h24);
        wb_write(A_STAT, 32'h4, 4'hF);
        wb_read(A_STAT, rd);
        check("err_clr", rd, 32'h20);

        // Request during DRAIN queues a second sequence
        base = done_cnt;
        wb_write(A_CFG, 32'd1, 4'hF);
        check("q_drain_oe", 32'(oe_enable), 32'd0);
        wb_write(A_CFG, 32'd3, 4'hF);
        wait_done(base + 2, "q_done");
        repeat (3) @(posedge clk);
        #1;
        check("q_ndone", 32'(done_cnt - base), 32'd2);
        check("q_gap", 32'(last_high), 32'd1);
        check("q_low", 32'(last_low), 32'd11);
        check("q_cfg", 32'(configuration), 32'd3);

        // Guard 0: 3 low cycles; same-value idle rewrite does nothing
        wb_write(A_GRD, 32'd0, 4'hF);
        wb_read(A_GRD, rd);
        check("g0_read", rd, 32'd0);
        base = done_cnt;
        wb_write(A_CFG, 32'd1, 4'hF);
        wait_done(base + 1, "g0_done");
        repeat (2) @(posedge clk);
        #1;
        check("g0_low", 32'(last_low), 32'd3);
        check("g0_cfg", 32'(configuration), 32'd1);
        base = done_cnt;
        wb_write(A_CFG, 32'd1, 4'hF);
        check("same_busy0", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("same_busy1", 32'(busy), 32'd0);
        check("same_oe", 32'(oe_enable), 32'd1);
        check("same_ndone", 32'(done_cnt - base), 32'd0);
        wb_read(A_STAT, rd);
        check("same_status", rd, 32'h10);
        wb_write(A_GRD, 32'h55, 4'h0);
        wb_read(A_GRD, rd);
        check("sel_none", rd, 32'd0);

        // Reset during SETTLE after switching to 3
        wb_write(A_GRD, 32'd7, 4'hF);
        wb_write(A_CFG, 32'd3, 4'hF);
        k = 0;
        while (configuration != 4'd3 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("mid_switched", 32'(configuration), 32'd3);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cfg", 32'(configuration), 32'd0);
        check("mid_rst_oe", 32'(oe_enable), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base  = done_cnt;
        wait_done(base + 1, "mid_rel_done");
        check("mid_rel_low", 32'(last_low), 32'd5);
        wb_read(A_GRD, rd);
        check("mid_guard", rd, 32'd4);
        wb_read(A_CFG, rd);
        check("mid_req", rd, 32'd0);

        // Out-of-range address is never acked
        wb.wbs_adr_i = BASE + 32'h10;
        wb.wbs_dat_i = 32'd1;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) acks++;
        end
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        check("unsel_ack", 32'(acks), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        wb_read(A_STAT, rd);
        check("unsel_status", rd, 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
